// File: rtl/vga_tx_pkg.sv
// ---------------------------------------------------------------------------
// vga_tx_pkg
// Shared types, default 640x480@60 timing and helpers for the VGA stream
// transmitter slice (vga_timing_gen, vga_stream_tx).
// ---------------------------------------------------------------------------
package vga_tx_pkg;

  // Transmitter FSM: WAIT_SOF drains/holds the stream until the frame origin,
  // STREAM forwards one pixel per visible pixel-enable.
  typedef enum logic {
    WAIT_SOF = 1'b0,
    STREAM   = 1'b1
  } tx_state_t;

  // Default 640x480@60 (25.175 MHz pixel clock) timing.
  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_RGB_W  = 3;

  // Pin level for a sync signal: active -> pol, inactive -> ~pol.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Horizontal/vertical position counters and raster decode.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset (counters -> (0,0))
//   pix_en_i     pixel-clock enable; counters advance only when high
//   visible_o    current position lies in the visible area
//   hsync_act_o  current position lies in the hsync pulse (logical, not pin)
//   vsync_act_o  current line lies in the vsync pulse (logical, not pin)
//   origin_o     current position is (0,0)
//
// All decode outputs describe the position that the next pix_en evaluates.
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_tx_pkg::*;
#(
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic clk,
  input  logic reset,
  input  logic pix_en_i,
  output logic visible_o,
  output logic hsync_act_o,
  output logic vsync_act_o,
  output logic origin_o
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  // Sized copies of the timing points so every compare is width-matched.
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_VISC = HW'(H_VIS);
  localparam logic [VW-1:0] V_VISC = VW'(V_VIS);
  localparam logic [HW-1:0] HS_BEG = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_VIS + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en_i) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign visible_o   = (h_q < H_VISC) && (v_q < V_VISC);
  assign hsync_act_o = (h_q >= HS_BEG) && (h_q <= HS_END);
  assign vsync_act_o = (v_q >= VS_BEG) && (v_q <= VS_END);
  assign origin_o    = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_stream_tx.sv
// ---------------------------------------------------------------------------
// vga_stream_tx
// VGA transmitter fed by a valid/ready pixel stream with a start-of-frame
// marker. Drives hsync/vsync/rgb/de with the configured raster timing and
// re-locks to the stream at the next frame origin after any error.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   pix_en       pixel-clock enable (one clk pulse per pixel)
//   s_valid      input pixel valid
//   s_ready      pixel accepted this clk when s_valid & s_ready (combinational)
//   s_sof        input pixel is (0,0) of a frame
//   s_rgb        input pixel colour
//   err_clr      clears the sticky flags (a same-clk set wins)
//   hsync/vsync  sync outputs, active level SYNC_POL
//   rgb          output colour, 0 outside the visible area / when not streaming
//   de           visible-area data enable
//   frame_start  one-clk pulse alongside output pixel (0,0) of a streamed frame
//   underflow    sticky: stream empty when a visible pixel was needed
//   sof_err      sticky: start-of-frame marker at the wrong position
//
// Raster outputs are registered on the pix_en clk, so they show the position
// evaluated by a pix_en one clk later and hold until the next pix_en.
// ---------------------------------------------------------------------------
module vga_stream_tx
  import vga_tx_pkg::*;
#(
  parameter int H_VIS    = DEF_H_VIS,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_VIS    = DEF_V_VIS,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int RGB_W    = DEF_RGB_W,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_sof,
  input  logic [RGB_W-1:0] s_rgb,
  input  logic             err_clr,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb,
  output logic             de,
  output logic             frame_start,
  output logic             underflow,
  output logic             sof_err
);

  logic visible, hs_act, vs_act, origin;

  vga_timing_gen #(
    .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .pix_en_i    (pix_en),
    .visible_o   (visible),
    .hsync_act_o (hs_act),
    .vsync_act_o (vs_act),
    .origin_o    (origin)
  );

  tx_state_t        state_q, state_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             fs_q, fs_d;
  logic             uf_q, uf_d;
  logic             se_q, se_d;

  // Per-pixel decisions, only meaningful while pix_en is high.
  logic [RGB_W-1:0] pix_rgb;
  logic             fs_set, uf_set, se_set;

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    pix_rgb = '0;
    fs_set  = 1'b0;
    uf_set  = 1'b0;
    se_set  = 1'b0;
    if (pix_en) begin
      case (state_q)
        WAIT_SOF: begin
          if (s_valid && !s_sof) begin
            // Drain leftovers of a broken frame, independent of raster position.
            s_ready = 1'b1;
          end else if (s_valid && s_sof && origin) begin
            s_ready = 1'b1;
            pix_rgb = s_rgb;
            fs_set  = 1'b1;
            state_d = STREAM;
          end
          // An sof pixel away from the origin is held until (0,0).
        end
        STREAM: begin
          if (visible) begin
            if (!s_valid) begin
              uf_set  = 1'b1;
              state_d = WAIT_SOF;
            end else if (s_sof && !origin) begin
              // Early sof: keep it, it starts the next frame.
              se_set  = 1'b1;
              state_d = WAIT_SOF;
            end else if (!s_sof && origin) begin
              // Missing sof at origin: the pixel belongs to a stale frame, drop it.
              s_ready = 1'b1;
              se_set  = 1'b1;
              state_d = WAIT_SOF;
            end else begin
              s_ready = 1'b1;
              pix_rgb = s_rgb;
              fs_set  = origin;
            end
          end
        end
        default: state_d = WAIT_SOF;
      endcase
    end
  end

  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    rgb_d   = rgb_q;
    if (pix_en) begin
      hsync_d = sync_level(hs_act, SYNC_POL);
      vsync_d = sync_level(vs_act, SYNC_POL);
      de_d    = visible;
      rgb_d   = pix_rgb;
    end
    // frame_start is a single-clk pulse, not held across the pixel period.
    fs_d = fs_set;
    uf_d = uf_set ? 1'b1 : (err_clr ? 1'b0 : uf_q);
    se_d = se_set ? 1'b1 : (err_clr ? 1'b0 : se_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= WAIT_SOF;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
      se_q    <= se_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
  assign sof_err     = se_q;

endmodule
